// File: rtl/fixed_point_iterative_divider.sv
// Restoring fixed-point divider, c = (a << d) / b, one quotient bit per clock, recv/send valid-ready streams.
// Define FXDIV_SIGN_EN for two's-complement operands (magnitude divide plus sign fix-up).
module fixed_point_iterative_divider #(
  parameter int n = 32,
  parameter int d = 16
) (
  input  logic         clk,
  input  logic         reset,
  output logic         recv_rdy,
  input  logic         recv_val,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         send_rdy,
  output logic         send_val,
  output logic [n-1:0] c
);

  localparam int W  = n + d;
  localparam int CW = $clog2(n + d + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [n-1:0]   divisor;
  logic [W-1:0]   dividend;
  logic [n-1:0]   remainder;
  logic [n-1:0]   quotient;
  logic [CW-1:0]  count;
  logic           accept;

  logic [n-1:0]   a_mag, b_mag;
  logic [n:0]     rem_shift;
  logic [n-1:0]   rem_sub;
  logic           ge;

`ifdef FXDIV_SIGN_EN
  logic neg_q, a_neg, b_zero;
  assign a_mag = a[n-1] ? -a : a;
  assign b_mag = b[n-1] ? -b : b;
`else
  assign a_mag = a;
  assign b_mag = b;
`endif

  // NOTE: every signal written in always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    recv_rdy  = 1'b0;
    send_val  = 1'b0;
    case (state)
      CALC: if (count == LAST_STEP) state_nxt = DONE;
      DONE: begin
        send_val = 1'b1;
        if (send_rdy) state_nxt = IDLE;
      end
      default: begin  // IDLE, and the unreachable code 3 behaves as IDLE
        recv_rdy = 1'b1;
        if (recv_val) state_nxt = CALC;
      end
    endcase
  end

  assign accept = recv_val && recv_rdy;

  // Remainder stays below the divisor, so the shifted value needs only one extra bit.
  assign rem_shift = {remainder, dividend[W-1]};
  assign ge        = rem_shift >= {1'b0, divisor};
  assign rem_sub   = rem_shift[n-1:0] - divisor;

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the datapath is a handful of flops, not a memory, so it is cleared by reset to keep c = 0 observable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      divisor   <= '0;
      dividend  <= '0;
      remainder <= '0;
      quotient  <= '0;
      count     <= '0;
`ifdef FXDIV_SIGN_EN
      neg_q     <= 1'b0;
      a_neg     <= 1'b0;
      b_zero    <= 1'b0;
`endif
    end else if (state == CALC) begin
      remainder <= ge ? rem_sub : rem_shift[n-1:0];
      dividend  <= {dividend[W-2:0], 1'b0};
      // Quotient bits above n-1 are discarded by the result rule, so they are never stored.
      quotient  <= {quotient[n-2:0], ge};
      count     <= count + CW'(1);
    end else if (accept) begin
      divisor   <= b_mag;
      dividend  <= W'(a_mag) << d;
      remainder <= '0;
      quotient  <= '0;
      count     <= '0;
`ifdef FXDIV_SIGN_EN
      neg_q     <= a[n-1] ^ b[n-1];
      a_neg     <= a[n-1];
      b_zero    <= (b == '0);
`endif
    end
  end

  always_comb begin
    c = '0;
    if (state == DONE) begin
`ifdef FXDIV_SIGN_EN
      if (b_zero)     c = a_neg ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}};
      else if (neg_q) c = -quotient;
      else            c = quotient;
`else
      c = quotient;
`endif
    end
  end

endmodule
